// File: rtl/mult_hilo_ctrl.sv
// Execute-stage HI/LO owner and serial multiplier initiator (MST/MSGN/SRCA/SRCB -> PROD/PRODV).
// Optional watchdog on the BUSY wait is enabled by defining MULT_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | multiplier held in reset (MRST=1) for 2 cycles, pipeline stalled
// S_IDLE  | accepts MULT/MULTU, MTHI/MTLO; reads never stall
// S_ISSUE | one-cycle MST pulse
// S_BLANK | 2 cycles where a stale PRODV from the previous product is ignored
// S_BUSY  | waiting for PRODV, then HI/LO capture
// S_TMO   | watchdog recovery: MRST pulsed 2 cycles, then back to IDLE
module mult_hilo_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EX_MULT,
    input  logic        EX_SIGNED,
    input  logic [31:0] EX_A,
    input  logic [31:0] EX_B,
    input  logic        EX_MFHI,
    input  logic        EX_MFLO,
    input  logic        EX_MTHI,
    input  logic        EX_MTLO,
    input  logic [31:0] EX_WDATA,
    output logic        STALL,
    output logic [31:0] HILO_RDATA,
    output logic        MST,
    output logic        MSGN,
    output logic [31:0] SRCA,
    output logic [31:0] SRCB,
    output logic        MRST,
    input  logic [63:0] PROD,
    input  logic        PRODV,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_BLANK,
        S_BUSY,
        S_TMO
    } state_t;

    state_t      state, state_nxt;
    logic        cnt, cnt_nxt;
    logic [31:0] hi, lo;
    logic        any_req;
    logic        capture;
    logic        tmo_fire;

    assign any_req = EX_MULT | EX_MFHI | EX_MFLO | EX_MTHI | EX_MTLO;
    assign capture = (state == S_BUSY) && PRODV;

`ifdef MULT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wd_cnt;
    logic          err_q;

    // Down-counter loaded in ISSUE so that counting begins at BLANK entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                wd_cnt <= TW'(TIMEOUT_CYCLES - 1);
            else if ((state == S_BLANK || state == S_BUSY) && wd_cnt != '0)
                wd_cnt <= wd_cnt - 1'b1;
            if (tmo_fire)
                err_q <= 1'b1;
        end
    end

    assign tmo_fire = (state == S_BUSY) && !PRODV && (wd_cnt == '0);
    assign ERR      = err_q;
`else
    assign tmo_fire = 1'b0;
    assign ERR      = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_INIT;
            cnt   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            SRCA  <= '0;
            SRCB  <= '0;
            MSGN  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE) begin
                if (EX_MULT) begin
                    SRCA <= EX_A;
                    SRCB <= EX_B;
                    MSGN <= EX_SIGNED;
                end
                if (EX_MTHI)
                    hi <= EX_WDATA;
                if (EX_MTLO)
                    lo <= EX_WDATA;
            end else if (capture) begin
                hi <= PROD[63:32];
                lo <= PROD[31:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_INIT, S_TMO: begin
                if (cnt) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 1'b0;
                end else begin
                    cnt_nxt = 1'b1;
                end
            end
            S_IDLE: begin
                if (EX_MULT)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_BLANK;
                cnt_nxt   = 1'b0;
            end
            S_BLANK: begin
                if (cnt) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = 1'b0;
                end else begin
                    cnt_nxt = 1'b1;
                end
            end
            S_BUSY: begin
                if (PRODV) begin
                    state_nxt = S_IDLE;
                end else if (tmo_fire) begin
                    state_nxt = S_TMO;
                    cnt_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = S_INIT;
                cnt_nxt   = 1'b0;
            end
        endcase
    end

    always_comb begin
        MST   = (state == S_ISSUE);
        MRST  = (state == S_INIT) || (state == S_TMO);
        STALL = 1'b0;
        case (state)
            S_INIT:  STALL = 1'b1;
            S_IDLE:  STALL = 1'b0;
            default: STALL = any_req;
        endcase
    end

    assign HILO_RDATA = EX_MFHI ? hi : (EX_MFLO ? lo : 32'h0);

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a behavioural serial multiplier (~33-cycle latency).
// The watchdog section is built only when MULT_TIMEOUT_EN is defined.
module tb_mult_hilo_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EX_MULT, EX_SIGNED, EX_MFHI, EX_MFLO, EX_MTHI, EX_MTLO;
    logic [31:0] EX_A, EX_B, EX_WDATA;
    logic        STALL, MST, MSGN, MRST, ERR;
    logic [31:0] HILO_RDATA, SRCA, SRCB;
    logic [63:0] PROD;
    logic        PRODV;

    int n_tests = 0;
    int n_fail  = 0;
    int mst_cnt = 0;

    always #5 CLK = ~CLK;

    mult_hilo_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .CLK(CLK), .RST(RST),
        .EX_MULT(EX_MULT), .EX_SIGNED(EX_SIGNED), .EX_A(EX_A), .EX_B(EX_B),
        .EX_MFHI(EX_MFHI), .EX_MFLO(EX_MFLO), .EX_MTHI(EX_MTHI), .EX_MTLO(EX_MTLO),
        .EX_WDATA(EX_WDATA), .STALL(STALL), .HILO_RDATA(HILO_RDATA),
        .MST(MST), .MSGN(MSGN), .SRCA(SRCA), .SRCB(SRCB), .MRST(MRST),
        .PROD(PROD), .PRODV(PRODV), .ERR(ERR)
    );

    // Serial multiplier stand-in: registers MST, samples operands the cycle after it,
    // drops PRODV at load and raises it (level) when the product is ready.
    logic        m_mst_q, m_busy, m_sgn, force_prodv0;
    logic [31:0] m_a, m_b;
    logic [5:0]  m_cnt;
    logic [63:0] m_prod;
    logic        m_prodv;
    assign PROD  = m_prod;
    assign PRODV = m_prodv;

    always @(posedge CLK) begin
        if (MRST) begin
            m_mst_q <= 1'b0;
            m_busy  <= 1'b0;
            m_prodv <= 1'b0;
            m_cnt   <= '0;
        end else begin
            m_mst_q <= MST;
            if (m_mst_q) begin
                m_a     <= SRCA;
                m_b     <= SRCB;
                m_sgn   <= MSGN;
                m_prodv <= 1'b0;
                m_busy  <= 1'b1;
                m_cnt   <= 6'd30;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy  <= 1'b0;
                    m_prodv <= !force_prodv0;
                    if (m_sgn)
                        m_prod <= 64'($signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b}));
                    else
                        m_prod <= {32'h0, m_a} * {32'h0, m_b};
                end else begin
                    m_cnt <= m_cnt - 1'b1;
                end
            end
        end
    end

    always @(posedge CLK) if (MST) mst_cnt <= mst_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_release(input string tag, output int cyc);
        cyc = 0;
        while (STALL && cyc < 100) begin
            tick();
            cyc++;
        end
        check(tag, {63'h0, STALL}, 64'h0);
    endtask

    // Assumes IDLE: request is accepted at the next edge.
    task automatic issue_mult(input logic [31:0] a, input logic [31:0] b, input logic s);
        EX_MULT = 1'b1; EX_A = a; EX_B = b; EX_SIGNED = s;
        #1;
        check("mult_no_stall_idle", {63'h0, STALL}, 64'h0);
        tick();
        EX_MULT = 1'b0;
        check("mst_high_issue", {63'h0, MST}, 64'h1);
        tick();
        check("mst_one_pulse", {63'h0, MST}, 64'h0);
    endtask

    int cyc;
    int mst_before;

    initial begin
        RST = 1'b0; force_prodv0 = 1'b0;
        EX_MULT = 0; EX_SIGNED = 0; EX_A = 0; EX_B = 0;
        EX_MFHI = 0; EX_MFLO = 0; EX_MTHI = 0; EX_MTLO = 0; EX_WDATA = 0;
        #3;
        check("rst_stall", {63'h0, STALL}, 64'h1);
        check("rst_mrst",  {63'h0, MRST},  64'h1);
        check("rst_mst",   {63'h0, MST},   64'h0);
        check("rst_err",   {63'h0, ERR},   64'h0);
        check("rst_srca",  {32'h0, SRCA},  64'h0);
        EX_MFHI = 1; #1;
        check("rst_hi", {32'h0, HILO_RDATA}, 64'h0);
        EX_MFHI = 0;
        tick(); tick();
        RST = 1'b1;
        tick();
        check("init_mrst_c1",  {63'h0, MRST},  64'h1);
        check("init_stall_c1", {63'h0, STALL}, 64'h1);
        tick();
        check("init_mrst_done", {63'h0, MRST},  64'h0);
        check("idle_no_stall",  {63'h0, STALL}, 64'h0);

        // MULTU 0xFFFFFFFF x 0xFFFFFFFF
        mst_before = mst_cnt;
        issue_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        EX_MFHI = 1; #1;
        check("mfhi_stalls_busy", {63'h0, STALL}, 64'h1);
        check("srca_held", {32'h0, SRCA}, 64'hFFFF_FFFF);
        check("srcb_held", {32'h0, SRCB}, 64'hFFFF_FFFF);
        wait_release("t1_release", cyc);
        check("t1_latency_le_37", {63'h0, (cyc + 2) <= 37}, 64'h1);
        check("t1_mst_count", 64'(mst_cnt - mst_before), 64'h1);
        check("t1_hi", {32'h0, HILO_RDATA}, 64'hFFFF_FFFE);
        EX_MFHI = 0; EX_MFLO = 1; #1;
        check("t1_lo", {32'h0, HILO_RDATA}, 64'h1);
        check("t1_lo_no_stall", {63'h0, STALL}, 64'h0);
        EX_MFLO = 0;

        // MULT -3 x 5, with PRODV from the last product still high in IDLE
        issue_mult(32'hFFFF_FFFD, 32'h5, 1'b1);
        repeat (5) tick();
        check("t2_msgn_busy", {63'h0, MSGN}, 64'h1);
        check("t2_unrelated_no_stall", {63'h0, STALL}, 64'h0);
        EX_MFLO = 1; #1;
        wait_release("t2_release", cyc);
        check("t2_lo", {32'h0, HILO_RDATA}, 64'hFFFF_FFF1);
        EX_MFLO = 0; EX_MFHI = 1; #1;
        check("t2_hi", {32'h0, HILO_RDATA}, 64'hFFFF_FFFF);
        EX_MFHI = 0;

        // Back-to-back MULTU 2x3 then 7x9; stale PRODV visible in BLANK
        issue_mult(32'd2, 32'd3, 1'b0);
        EX_MULT = 1; EX_A = 32'd7; EX_B = 32'd9; EX_SIGNED = 0; #1;
        check("t3_second_stalled", {63'h0, STALL}, 64'h1);
        wait_release("t3_release", cyc);
        tick();
        EX_MULT = 0;
        check("t3_second_mst", {63'h0, MST}, 64'h1);
        EX_MFLO = 1; #1;
        wait_release("t3_release2", cyc);
        check("t3_lo", {32'h0, HILO_RDATA}, 64'd63);
        EX_MFLO = 0; EX_MFHI = 1; #1;
        check("t3_hi", {32'h0, HILO_RDATA}, 64'd0);
        EX_MFHI = 0;

        // MTLO then MFLO in IDLE
        EX_MTLO = 1; EX_WDATA = 32'h1234_5678; #1;
        check("t4_mtlo_no_stall", {63'h0, STALL}, 64'h0);
        tick();
        EX_MTLO = 0; EX_MFLO = 1; #1;
        check("t4_mflo_no_stall", {63'h0, STALL}, 64'h0);
        check("t4_mflo", {32'h0, HILO_RDATA}, 64'h1234_5678);
        EX_MFLO = 0;

        // MTHI during BUSY stalls until capture, then lands after the product
        issue_mult(32'd10, 32'd10, 1'b0);
        repeat (3) tick();
        EX_MTHI = 1; EX_WDATA = 32'hCAFE_0000; #1;
        check("t4_mthi_stall", {63'h0, STALL}, 64'h1);
        wait_release("t4_release", cyc);
        tick();
        EX_MTHI = 0; EX_MFHI = 1; #1;
        check("t4_hi_mt", {32'h0, HILO_RDATA}, 64'hCAFE_0000);
        EX_MFHI = 0; EX_MFLO = 1; #1;
        check("t4_lo_prod", {32'h0, HILO_RDATA}, 64'd100);
        EX_MFLO = 0;

        // Reset mid-BUSY
        issue_mult(32'd5, 32'd5, 1'b0);
        repeat (5) tick();
        RST = 1'b0; EX_MFLO = 1; #1;
        check("t5_rst_mst",  {63'h0, MST},  64'h0);
        check("t5_rst_mrst", {63'h0, MRST}, 64'h1);
        check("t5_rst_lo",   {32'h0, HILO_RDATA}, 64'h0);
        tick();
        RST = 1'b1;
        tick();
        check("t5_mrst_c1",  {63'h0, MRST},  64'h1);
        check("t5_stall_c1", {63'h0, STALL}, 64'h1);
        tick();
        check("t5_mrst_done", {63'h0, MRST},  64'h0);
        check("t5_idle",      {63'h0, STALL}, 64'h0);
        EX_MFLO = 0;
        issue_mult(32'd4, 32'd4, 1'b0);
        EX_MFLO = 1; #1;
        wait_release("t5_release", cyc);
        check("t5_lo16", {32'h0, HILO_RDATA}, 64'd16);
        EX_MFLO = 0;

`ifdef MULT_TIMEOUT_EN
        force_prodv0 = 1'b1;
        issue_mult(32'd3, 32'd3, 1'b0);
        cyc = 0;
        while (!ERR && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t6_err_set", {63'h0, ERR}, 64'h1);
        check("t6_err_timing", {63'h0, (cyc >= 60) && (cyc <= 66)}, 64'h1);
        check("t6_mrst_c1", {63'h0, MRST}, 64'h1);
        tick();
        check("t6_mrst_c2", {63'h0, MRST}, 64'h1);
        tick();
        check("t6_mrst_done", {63'h0, MRST},  64'h0);
        check("t6_idle",      {63'h0, STALL}, 64'h0);
        EX_MFLO = 1; #1;
        check("t6_lo_kept", {32'h0, HILO_RDATA}, 64'd16);
        EX_MFLO = 0;
        repeat (5) tick();
        check("t6_err_sticky", {63'h0, ERR}, 64'h1);
        RST = 1'b0; #1;
        check("t6_err_clear", {63'h0, ERR}, 64'h0);
        tick();
        RST = 1'b1; force_prodv0 = 1'b0;
        repeat (3) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
